// File: rtl/div_iter_pkg.sv
// rtl/div_iter_pkg.sv - state encoding and handshake constants for div_iter
package div_iter_pkg;

  typedef enum logic [1:0] {
    DIV_FREE    = 2'b00,
    DIV_BY_ZERO = 2'b01,
    DIV_ON      = 2'b10,
    DIV_END     = 2'b11
  } div_state_e;

  localparam logic DIV_RESULT_READY     = 1'b1;
  localparam logic DIV_RESULT_NOT_READY = 1'b0;
  localparam logic DIV_START            = 1'b1;
  localparam logic DIV_STOP             = 1'b0;

endpackage

// File: rtl/div_iter.sv
// rtl/div_iter.sv - multi-cycle restoring divider, one quotient bit per clock
module div_iter
  import div_iter_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 signed_div_i,
  input  logic [WIDTH-1:0]     opdata1_i,
  input  logic [WIDTH-1:0]     opdata2_i,
  input  logic                 start_i,
  input  logic                 annul_i,
  output logic [2*WIDTH-1:0]   result_o,
  output logic                 ready_o,
  output logic                 busy_o
);

  localparam int CW = $clog2(WIDTH) + 1;

  div_state_e         state_q, state_d;
  logic [CW-1:0]      cnt_q;
  logic [WIDTH-1:0]   rem_q;
  // Holds the dividend magnitude; quotient bits shift in from the LSB as
  // dividend bits leave from the MSB, so after WIDTH steps it is the quotient.
  // On divide-by-zero it keeps the raw dividend for the remainder field.
  logic [WIDTH-1:0]   dq_q;
  logic [WIDTH-1:0]   dvs_q;
  logic               mode_q, sign1_q, sign2_q;
  logic [2*WIDTH-1:0] result_q;
  logic               ready_q, busy_q;

  logic               accept, div_zero, last_step;
  logic [WIDTH-1:0]   abs1, abs2;
  logic [WIDTH:0]     rem_shift;
  logic               ge;
  logic [WIDTH-1:0]   rem_nx, dq_nx, q_fix, r_fix;

  assign accept    = (start_i == DIV_START) && !annul_i;
  assign div_zero  = (opdata2_i == '0);
  assign last_step = (cnt_q == CW'(WIDTH - 1));
  assign abs1      = (signed_div_i && opdata1_i[WIDTH-1]) ? -opdata1_i : opdata1_i;
  assign abs2      = (signed_div_i && opdata2_i[WIDTH-1]) ? -opdata2_i : opdata2_i;

  // One extra remainder bit keeps the compare correct when the divisor MSB is set.
  assign rem_shift = {rem_q, dq_q[WIDTH-1]};
  assign ge        = (rem_shift >= {1'b0, dvs_q});
  assign rem_nx    = ge ? WIDTH'(rem_shift - {1'b0, dvs_q}) : rem_shift[WIDTH-1:0];
  assign dq_nx     = {dq_q[WIDTH-2:0], ge};
  assign q_fix     = (mode_q && (sign1_q ^ sign2_q)) ? -dq_nx : dq_nx;
  assign r_fix     = (mode_q && sign1_q) ? -rem_nx : rem_nx;

  assign result_o  = result_q;
  assign ready_o   = ready_q;
  assign busy_o    = busy_q;

  // State register; reset overrides any state, including mid-division.
  always_ff @(posedge clk) begin
    if (!rst) state_q <= DIV_FREE;
    else      state_q <= state_d;
  end

  // Next-state logic; annul aborts any non-idle state back to FREE.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      DIV_FREE: begin
        if (accept) state_d = div_zero ? DIV_BY_ZERO : DIV_ON;
      end
      DIV_BY_ZERO: begin
        if (annul_i)                state_d = DIV_FREE;
        else if (cnt_q == CW'(1))   state_d = DIV_END;
      end
      DIV_ON: begin
        if (annul_i)        state_d = DIV_FREE;
        else if (last_step) state_d = DIV_END;
      end
      DIV_END: begin
        if (annul_i || start_i == DIV_STOP) state_d = DIV_FREE;
      end
      default: state_d = DIV_FREE;
    endcase
  end

  // Datapath and registered outputs; result is zero outside END and frozen in END.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q    <= '0;
      rem_q    <= '0;
      dq_q     <= '0;
      dvs_q    <= '0;
      mode_q   <= 1'b0;
      sign1_q  <= 1'b0;
      sign2_q  <= 1'b0;
      result_q <= '0;
      ready_q  <= DIV_RESULT_NOT_READY;
      busy_q   <= 1'b0;
    end else begin
      ready_q <= (state_d == DIV_END) ? DIV_RESULT_READY : DIV_RESULT_NOT_READY;
      busy_q  <= (state_d == DIV_BY_ZERO) || (state_d == DIV_ON);
      if (state_d != DIV_END)           result_q <= '0;
      else if (state_q == DIV_BY_ZERO)  result_q <= {dq_q, {WIDTH{1'b1}}};
      else if (state_q == DIV_ON)       result_q <= {r_fix, q_fix};
      unique case (state_q)
        DIV_FREE: begin
          if (accept) begin
            cnt_q   <= '0;
            rem_q   <= '0;
            dq_q    <= div_zero ? opdata1_i : abs1;
            dvs_q   <= abs2;
            mode_q  <= signed_div_i;
            sign1_q <= opdata1_i[WIDTH-1];
            sign2_q <= opdata2_i[WIDTH-1];
          end
        end
        DIV_BY_ZERO: cnt_q <= cnt_q + CW'(1);
        DIV_ON: begin
          if (!annul_i) begin
            rem_q <= rem_nx;
            dq_q  <= dq_nx;
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
